// File: rtl/wb_mem_checker.sv
`default_nettype none
// ============================================================================
// Module   : wb_mem_checker
// Purpose  : Wishbone classic master that writes a seed+index pattern over a
//            programmed word range, reads it back, and compares every word.
//            Intended as a synthesizable traffic source ahead of the SDRAM
//            controller's Wishbone slave port.
// Ports    : sys_clk, resetn (sync, active low)
//            start_i / base_addr_i / len_i / seed_i : run request + parameters
//            wb_cyc_o .. wb_dat_o, wb_dat_i, wb_ack_i : Wishbone master side
//            busy_o, done_o, pass_o, timeout_o, err_cnt_o, first_err_addr_o :
//            run status and results
// Revision : 1.0  initial release
// ============================================================================
module wb_mem_checker #(
   parameter int dw     = 32,
   parameter int APP_AW = 26,
   parameter int LEN_W  = 16,
   parameter int TMO    = 255
) (
   input  logic              sys_clk,
   input  logic              resetn,
   input  logic              start_i,
   input  logic [APP_AW-1:0] base_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [dw-1:0]     seed_i,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [APP_AW-1:0] wb_addr_o,
   output logic [dw/8-1:0]   wb_sel_o,
   output logic [dw-1:0]     wb_dat_o,
   input  logic [dw-1:0]     wb_dat_i,
   input  logic              wb_ack_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              timeout_o,
   output logic [LEN_W-1:0]  err_cnt_o,
   output logic [APP_AW-1:0] first_err_addr_o
);

   localparam int TMO_W = $clog2(TMO + 1);
   localparam logic [APP_AW-1:0] c_stride   = APP_AW'(dw / 8);
   localparam logic [TMO_W-1:0]  c_tmo_last = TMO_W'(TMO - 1);
   localparam logic [LEN_W-1:0]  c_err_max  = {LEN_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WRITE  = 3'd1,
      S_WGAP   = 3'd2,
      S_READ   = 3'd3,
      S_RGAP   = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t            r_state;
   logic [LEN_W-1:0]  r_k;
   logic [LEN_W-1:0]  r_len;
   logic [APP_AW-1:0] r_base;
   logic [dw-1:0]     r_exp;      // data(k) expected on the current read
   logic [TMO_W-1:0]  r_tmo;
   logic              r_cyc;
   logic              r_we;
   logic [APP_AW-1:0] r_addr;
   logic [dw/8-1:0]   r_sel;
   logic [dw-1:0]     r_dat;
   logic              r_done;
   logic              r_pass;
   logic              r_timeout;
   logic [LEN_W-1:0]  r_err_cnt;
   logic [APP_AW-1:0] r_first_err;

   logic w_last;
   logic w_tmo_hit;

   assign w_last    = (r_k == r_len - LEN_W'(1));
   // Ack has priority: an ack in the cycle the counter would reach TMO wins.
   assign w_tmo_hit = r_cyc && !wb_ack_i && (r_tmo == c_tmo_last);

   always_ff @(posedge sys_clk) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_len       <= '0;
         r_base      <= '0;
         r_exp       <= '0;
         r_tmo       <= '0;
         r_cyc       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_sel       <= '0;
         r_dat       <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_timeout   <= 1'b0;
         r_err_cnt   <= '0;
         r_first_err <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_base      <= base_addr_i;
                  r_len       <= len_i;
                  r_exp       <= seed_i;
                  r_k         <= '0;
                  r_tmo       <= '0;
                  r_addr      <= base_addr_i;
                  r_dat       <= seed_i;
                  r_err_cnt   <= '0;
                  r_first_err <= '0;
                  r_pass      <= 1'b0;
                  r_timeout   <= 1'b0;
                  r_state     <= (len_i == '0) ? S_FINISH : S_WRITE;
               end
            end
            S_WRITE: begin
               if (!r_cyc) begin
                  // Launch cycle after start: address/data already loaded.
                  r_cyc <= 1'b1;
                  r_we  <= 1'b1;
                  r_sel <= '1;
               end else if (wb_ack_i) begin
                  r_cyc   <= 1'b0;
                  r_sel   <= '0;
                  r_tmo   <= '0;
                  r_state <= S_WGAP;
               end else if (w_tmo_hit) begin
                  r_cyc     <= 1'b0;
                  r_sel     <= '0;
                  r_tmo     <= '0;
                  r_timeout <= 1'b1;
                  r_pass    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= S_FINISH;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            S_WGAP: begin
               r_cyc <= 1'b1;
               r_sel <= '1;
               if (w_last) begin
                  r_k     <= '0;
                  r_we    <= 1'b0;
                  r_addr  <= r_base;
                  r_state <= S_READ;
               end else begin
                  r_k     <= r_k + LEN_W'(1);
                  r_addr  <= r_addr + c_stride;
                  r_dat   <= r_dat + dw'(1);
                  r_state <= S_WRITE;
               end
            end
            S_READ: begin
               if (wb_ack_i) begin
                  r_cyc   <= 1'b0;
                  r_sel   <= '0;
                  r_tmo   <= '0;
                  r_state <= S_RGAP;
                  if (wb_dat_i != r_exp) begin
                     if (r_err_cnt != c_err_max) begin
                        r_err_cnt <= r_err_cnt + LEN_W'(1);
                     end
                     if (r_err_cnt == '0) begin
                        r_first_err <= r_addr;
                     end
                  end
               end else if (w_tmo_hit) begin
                  r_cyc     <= 1'b0;
                  r_sel     <= '0;
                  r_tmo     <= '0;
                  r_timeout <= 1'b1;
                  r_pass    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= S_FINISH;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            S_RGAP: begin
               if (w_last) begin
                  r_done  <= 1'b1;
                  r_pass  <= (r_err_cnt == '0) && !r_timeout;
                  r_state <= S_FINISH;
               end else begin
                  r_k     <= r_k + LEN_W'(1);
                  r_addr  <= r_addr + c_stride;
                  r_exp   <= r_exp + dw'(1);
                  r_cyc   <= 1'b1;
                  r_sel   <= '1;
                  r_state <= S_READ;
               end
            end
            S_FINISH: begin
               // Runs that did traffic arrive with done already raised. A
               // zero-length run arrives with done low and raises it here,
               // which mirrors the launch cycle a non-empty run spends.
               if (r_done) begin
                  r_state <= S_IDLE;
               end else begin
                  r_done <= 1'b1;
                  r_pass <= (r_err_cnt == '0) && !r_timeout;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wb_cyc_o         = r_cyc;
   assign wb_stb_o         = r_cyc;
   assign wb_we_o          = r_we;
   assign wb_addr_o        = r_addr;
   assign wb_sel_o         = r_sel;
   assign wb_dat_o         = r_dat;
   assign busy_o           = (r_state != S_IDLE);
   assign done_o           = r_done;
   assign pass_o           = r_pass;
   assign timeout_o        = r_timeout;
   assign err_cnt_o        = r_err_cnt;
   assign first_err_addr_o = r_first_err;

endmodule
`default_nettype wire

// File: doc/wb_mem_checker.md
Name: wb_mem_checker

Overview:
- Wishbone classic master that generates self-checking traffic into the SDRAM controller's Wishbone slave port; sits directly upstream of the controller's Wishbone interface.
- On start it writes a deterministic pattern over a programmed address range, reads the range back, and compares each word.
- Reports pass/fail, error count, first failing address and ack timeout.
- Used as a synthesizable traffic source in bring-up and regression benches.

Parameters:
- dw, 32, Wishbone data width in bits (matches SDR_DW).
- APP_AW, 26, Wishbone byte-address width.
- LEN_W, 16, width of word-count and error-count fields.
- TMO, 255, maximum cycles to wait for wb_ack_i per transfer before abort.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- base_addr_i  in  APP_AW  byte address of word 0; captured on accepted start.
- len_i  in  LEN_W  number of words to test; captured on accepted start.
- seed_i  in  dw  pattern seed; captured on accepted start.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  1 = write, 0 = read.
- wb_addr_o  out  APP_AW  byte address.
- wb_sel_o  out  dw/8  byte selects; all ones during a transfer.
- wb_dat_o  out  dw  write data.
- wb_dat_i  in  dw  read data; valid when wb_ack_i = 1.
- wb_ack_i  in  1  slave acknowledge.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- pass_o  out  1  1 = no mismatches and no timeout; held until next accepted start.
- timeout_o  out  1  ack timeout occurred; held until next accepted start.
- err_cnt_o  out  LEN_W  mismatch count; saturates at all ones.
- first_err_addr_o  out  APP_AW  address of first mismatch; 0 if none.

Behaviour:
- Reset (resetn = 0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0, except wb_sel_o = 0 and pass_o = 0.
  - Internal index, timeout counter and captured values are cleared.
  - Reset mid-transfer drops cyc/stb on the next edge; no completion is reported.
- Pattern: word k (k = 0 .. len-1):
  - addr(k) = base + k*(dw/8), modulo 2^APP_AW (wraps silently).
  - data(k) = seed + k, modulo 2^dw.
- FSM states: IDLE, WRITE, WGAP, READ, RGAP, FINISH.
- IDLE:
  - start_i = 1 captures the inputs and clears err_cnt, first_err_addr, pass and timeout.
  - If len = 0, go to FINISH. Otherwise go to WRITE with k = 0.
  - start_i is ignored while busy_o = 1.
- WRITE:
  - Drive cyc = stb = we = 1, addr(k), data(k), sel all ones. Outputs are stable until ack.
  - On wb_ack_i: go to WGAP.
- WGAP:
  - cyc = stb = 0 for exactly one cycle.
  - If k = len-1, go to READ with k = 0; else go to WRITE with k+1.
- READ:
  - Drive cyc = stb = 1, we = 0, addr(k).
  - On wb_ack_i: compare wb_dat_i with data(k) in the same cycle, then go to RGAP.
  - On mismatch: err_cnt += 1 (saturating); on the first mismatch latch first_err_addr = addr(k).
- RGAP:
  - One idle cycle.
  - If k = len-1, go to FINISH; else go to READ with k+1.
- FINISH:
  - done_o = 1 for one cycle.
  - pass_o = (err_cnt == 0) and not timeout.
  - Next state IDLE.
- Latency:
  - Accepted start at edge n gives cyc/stb high after edge n+1.
  - Single-cycle ack gives 3 cycles per word per phase (request, ack cycle, gap).
  - With len = L and immediate acks, done_o asserts 6L+1 cycles after the accepted start.
- Timeout:
  - The counter increments each cycle in WRITE/READ without ack and clears on ack.
  - When it reaches TMO: set timeout_o, drop cyc/stb, go to FINISH (pass_o = 0).
  - An ack arriving in the same cycle the counter reaches TMO is honoured; no timeout.
- Ack outside WRITE/READ is ignored.
- wb_dat_i is not used when wb_ack_i = 0.

Test Plan:
- Zero-wait slave model, base = 0x100, len = 4, seed = 0xA5A50000:
  - Writes go to 0x100/0x104/0x108/0x10C with data 0xA5A50000..0xA5A50003.
  - Readback matches, pass_o = 1, err_cnt_o = 0, done_o high 25 cycles after start.
- Slave corrupts the read of word 2 (bit 0 flipped), len = 4: err_cnt_o = 1, first_err_addr_o = 0x108, pass_o = 0.
- Slave never acks the first write, TMO = 255:
  - cyc/stb drop after 255 cycles; timeout_o = 1, pass_o = 0, done_o pulses once.
- len = 0: done_o one cycle after start, pass_o = 1, wb_cyc_o never asserted.
- Address wrap, base = 0x3FFFFFC, len = 2: second address is 0x0000000, pass_o = 1.
- Disturbances:
  - resetn low during READ of word 1 with 3-cycle ack latency: wb_cyc_o = 0 and busy_o = 0 after that edge, no done_o.
  - start_i pulsed while busy: ignored, with len/seed unchanged.
